// File: rtl/cordic_pipe_prerot.sv
// cordic_pipe_prerot: input stage of the CORDIC rotation pipeline.
// Accepts (x, y, z) over valid/ready, applies a +/-90 degree quadrant
// pre-rotation so the residual angle lies in [-90, +90), and presents the
// registered result to pipe stage 0. A 2-entry skid (output regs + one skid
// reg) keeps s_ready registered while the pipeline is stalled by en.
//
// Optional build macro: CORDIC_PREROT_SAT_EN -- when defined, negating the
// most-negative x/y value saturates to the most-positive value instead of
// wrapping to itself.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_valid, s_ready  upstream handshake (s_ready registered)
//   x_i, y_i, z_i     sample in (z_i: 2^32 = 360 degrees)
//   en                pipeline advance shared with downstream stages
//   m_valid           outputs hold a real sample
//   x_o, y_o, z_o     pre-rotated sample to stage 0
//   quad_o            z_i[31:30] of the sample on the outputs
module cordic_pipe_prerot #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic signed [DATA_WIDTH-1:0] x_i,
   input  logic signed [DATA_WIDTH-1:0] y_i,
   input  logic        [31:0]           z_i,
   input  logic                         en,
   output logic                         m_valid,
   output logic signed [DATA_WIDTH-1:0] x_o,
   output logic signed [DATA_WIDTH-1:0] y_o,
   output logic        [31:0]           z_o,
   output logic        [1:0]            quad_o
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   localparam logic [31:0] QUARTER_TURN = 32'h4000_0000;
   localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = ~MIN_VAL;

   logic [1:0] state, next_state;

   // transformed sample
   logic signed [DATA_WIDTH-1:0] tx, ty;
   logic        [31:0]           tz;

   // skid register
   logic signed [DATA_WIDTH-1:0] skid_x, skid_y;
   logic        [31:0]           skid_z;
   logic        [1:0]            skid_q;

   logic accept, consume;
   logic load_out, load_skid, pop_skid;
   logic m_valid_nxt, s_ready_nxt;

   // negation used by the quadrant swap
   function automatic logic signed [DATA_WIDTH-1:0] negate(input logic signed [DATA_WIDTH-1:0] v);
`ifdef CORDIC_PREROT_SAT_EN
      if (v == MIN_VAL) negate = MAX_VAL;
      else              negate = -v;
`else
      negate = -v;
`endif
   endfunction

   assign accept  = s_valid && s_ready;
   assign consume = en && m_valid;

   // quadrant pre-rotation by +/-90 degrees
   always_comb begin
      tx = x_i;
      ty = y_i;
      tz = z_i;
      case (z_i[31:30])
         2'b01: begin
            tx = negate(y_i);
            ty = x_i;
            tz = z_i - QUARTER_TURN;
         end
         2'b10: begin
            tx = y_i;
            ty = negate(x_i);
            tz = z_i + QUARTER_TURN;
         end
         default: begin
            tx = x_i;
            ty = y_i;
            tz = z_i;
         end
      endcase
   end

   // next-state and register-load decode
   always_comb begin
      next_state  = state;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      pop_skid    = 1'b0;
      m_valid_nxt = m_valid;
      case (state)
         EMPTY: begin
            if (accept) begin
               load_out    = 1'b1;
               m_valid_nxt = 1'b1;
               next_state  = ONE;
            end
         end
         ONE: begin
            if (accept && consume) begin
               load_out = 1'b1;
            end else if (accept) begin
               load_skid  = 1'b1;
               next_state = FULL;
            end else if (consume) begin
               m_valid_nxt = 1'b0;
               next_state  = EMPTY;
            end
         end
         FULL: begin
            if (consume) begin
               pop_skid   = 1'b1;
               next_state = ONE;
            end
         end
         default: begin
            m_valid_nxt = 1'b0;
            next_state  = EMPTY;
         end
      endcase
      s_ready_nxt = (next_state != FULL);
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= next_state;
   end

   // output and skid registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         s_ready <= 1'b1;
         x_o     <= '0;
         y_o     <= '0;
         z_o     <= '0;
         quad_o  <= '0;
         skid_x  <= '0;
         skid_y  <= '0;
         skid_z  <= '0;
         skid_q  <= '0;
      end else begin
         m_valid <= m_valid_nxt;
         s_ready <= s_ready_nxt;
         if (load_out) begin
            x_o    <= tx;
            y_o    <= ty;
            z_o    <= tz;
            quad_o <= z_i[31:30];
         end else if (pop_skid) begin
            x_o    <= skid_x;
            y_o    <= skid_y;
            z_o    <= skid_z;
            quad_o <= skid_q;
         end
         if (load_skid) begin
            skid_x <= tx;
            skid_y <= ty;
            skid_z <= tz;
            skid_q <= z_i[31:30];
         end
      end
   end

endmodule

// File: tb/tb_cordic_pipe_prerot.sv
// Scoreboard bench for cordic_pipe_prerot: stimulus pushes the expected
// pre-rotated sample at accept, a monitor pops and compares on every consume.
module tb_cordic_pipe_prerot;

   localparam int unsigned DW = 16;
`ifdef CORDIC_PREROT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic [31:0]   z;
      logic [1:0]    q;
   } sample_t;

   logic          clk, rst, s_valid, s_ready, en, m_valid;
   logic [DW-1:0] x_i, y_i, x_o, y_o;
   logic [31:0]   z_i, z_o;
   logic [1:0]    quad_o;

   logic rand_en, en_force;
   int   vectors, miscompares;
   sample_t sb[$];

   cordic_pipe_prerot #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .x_i(x_i), .y_i(y_i), .z_i(z_i), .en(en),
      .m_valid(m_valid), .x_o(x_o), .y_o(y_o), .z_o(z_o), .quad_o(quad_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // en driver: either forced or randomly stalling
   initial begin
      en = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         en = rand_en ? ($urandom_range(0, 3) != 0) : en_force;
      end
   end

   // reference: rotate the vector by -90 or +90 degrees using integer math
   function automatic int neg_model(input int v);
      int n;
      n = -v;
      if (n > (1 << (DW - 1)) - 1) n = SAT ? (1 << (DW - 1)) - 1 : -(1 << (DW - 1));
      return n;
   endfunction

   function automatic sample_t model(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [31:0] z);
      sample_t r;
      int xs, ys, xe, ye;
      xs = $signed(x);
      ys = $signed(y);
      xe = xs;
      ye = ys;
      r.z = z;
      r.q = z[31:30];
      if (r.q == 2'b01) begin
         xe  = neg_model(ys);
         ye  = xs;
         r.z = z - 32'h4000_0000;
      end else if (r.q == 2'b10) begin
         xe  = ys;
         ye  = neg_model(xs);
         r.z = z + 32'h4000_0000;
      end
      r.x = DW'(xe);
      r.y = DW'(ye);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every consume must match the oldest outstanding accept
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && m_valid && en) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_output: got x=0x%0h z=0x%0h, expected no sample at %0t", x_o, z_o, $time);
            end else begin
               sample_t e;
               e = sb.pop_front();
               chk("sb_x", 32'(x_o), 32'(e.x));
               chk("sb_y", 32'(y_o), 32'(e.y));
               chk("sb_z", z_o, e.z);
               chk("sb_q", 32'(quad_o), 32'(e.q));
            end
         end
      end
   end

   // present a sample and hold it until accepted; push the expectation
   task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [31:0] z, output sample_t e);
      bit done;
      done = 1'b0;
      e = model(x, y, z);
      @(posedge clk);
      #1;
      s_valid = 1'b1;
      x_i = x;
      y_i = y;
      z_i = z;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk);
         if (s_ready) begin
            sb.push_back(e);
            done = 1'b1;
         end
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: got s_ready=0, expected 1 within 1000 cycles");
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic chk_out(input string name, input sample_t e);
      chk({name, "_x"}, 32'(x_o), 32'(e.x));
      chk({name, "_y"}, 32'(y_o), 32'(e.y));
      chk({name, "_z"}, z_o, e.z);
      chk({name, "_q"}, 32'(quad_o), 32'(e.q));
   endtask

   initial begin
      sample_t a, b, c, k;
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      en_force = 1'b1;
      rand_en = 1'b0;
      s_valid = 1'b0;
      x_i = '0;
      y_i = '0;
      z_i = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_data", {x_o, y_o} | z_o | 32'(quad_o), 32'd0);
      rst = 1'b0;

      // idle with en=1: bubbles ignored
      repeat (5) idle();
      chk("idle_m_valid", 32'(m_valid), 32'd0);
      chk("idle_s_ready", 32'(s_ready), 32'd1);
      chk("idle_data", {x_o, y_o} | z_o | 32'(quad_o), 32'd0);

      // 135 degrees: rotate by -90
      send(16'h4000, 16'h0000, 32'h6000_0000, k);
      idle();
      chk("q1_m_valid", 32'(m_valid), 32'd1);
      chk("q1_x", 32'(x_o), 32'h0000);
      chk("q1_y", 32'(y_o), 32'h4000);
      chk("q1_z", z_o, 32'h2000_0000);
      chk("q1_q", 32'(quad_o), 32'd1);

      // -180 degrees: rotate by +90
      send(16'h1000, 16'h0200, 32'h8000_0000, k);
      idle();
      chk("q2_x", 32'(x_o), 32'h0200);
      chk("q2_y", 32'(y_o), 32'hF000);
      chk("q2_z", z_o, 32'hC000_0000);

      // -90 degrees: pass-through
      send(16'h1234, 16'h0567, 32'hC000_0000, k);
      idle();
      chk("q3_x", 32'(x_o), 32'h1234);
      chk("q3_y", 32'(y_o), 32'h0567);
      chk("q3_z", z_o, 32'hC000_0000);

      // most-negative y under -90 rotation
      send(16'h1111, 16'h8000, 32'h4000_0000, k);
      idle();
      chk("neg_min_x", 32'(x_o), SAT ? 32'h7FFF : 32'h8000);
      chk("neg_min_y", 32'(y_o), 32'h1111);
      chk("neg_min_z", z_o, 32'h0000_0000);
      repeat (2) idle();

      // backpressure: A on outputs, B in skid
      @(posedge clk);
      #1;
      en_force = 1'b0;
      send(16'h0123, 16'h0456, 32'h1000_0000, a);
      send(16'h0789, 16'h0ABC, 32'h5000_0000, b);
      idle();
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      repeat (3) idle();
      chk("bp_hold_ready", 32'(s_ready), 32'd0);
      chk_out("bp_hold_a", a);
      @(posedge clk);
      #1;
      en_force = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_ready_back", 32'(s_ready), 32'd1);
      chk_out("bp_b", b);
      repeat (3) idle();

      // reset while FULL discards held samples
      @(posedge clk);
      #1;
      en_force = 1'b0;
      send(16'h7001, 16'h7002, 32'h2000_0000, a);
      send(16'h7003, 16'h7004, 32'hA000_0000, b);
      idle();
      chk("full_before_rst", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("rst_full_m_valid", 32'(m_valid), 32'd0);
      chk("rst_full_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      en_force = 1'b1;
      send(16'h0C0C, 16'hF0F0, 32'hE000_0000, c);
      idle();
      chk("post_rst_m_valid", 32'(m_valid), 32'd1);
      chk_out("post_rst_c", c);
      repeat (3) idle();

      // randomized traffic with random stalls
      rand_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         logic [DW-1:0] rx, ry;
         if ($urandom_range(0, 3) == 0) idle();
         rx = ($urandom_range(0, 7) == 0) ? 16'h8000 : DW'($urandom);
         ry = ($urandom_range(0, 7) == 0) ? 16'h8000 : DW'($urandom);
         send(rx, ry, $urandom, k);
      end
      idle();
      rand_en = 1'b0;
      en_force = 1'b1;
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk("drain_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
